pd_debug_cnt_bank: RTL and testbench

Statistics counter bank directly downstream of the PD debug match stage. It consumes the six dbg2cif increment strobes and the byte-increment amount, and accumulates them into four event counters and two byte counters. Counters are exposed to the CIF through a single-outstanding read port with clear-on-read, a global clear, selectable saturate/wrap behaviour and sticky overflow flags.

---
 rtl/pd_debug_pkg.sv | 30 +++
 rtl/pd_debug_sat_cnt.sv | 45 ++++
 rtl/pd_debug_cnt_bank.sv | 166 ++++++++++++++++
 tb/tb_pd_debug_cnt_bank.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_debug_pkg.sv
// Shared definitions for the PD debug statistics counter bank.
package pd_debug_pkg;

   localparam int DEFAULT_CNT_WIDTH         = 32;
   localparam int DEFAULT_BYTE_CNT_WIDTH    = 48;
   localparam int DEFAULT_PACKET_SIZE_WIDTH = 14;
   localparam int RD_DATA_WIDTH             = 32;
   localparam int NUM_CNT                   = 6;

   // CIF read address map
   typedef enum logic [2:0] {
      ADDR_F1_CNT     = 3'd0,
      ADDR_F2_CNT     = 3'd1,
      ADDR_CAP_CNT    = 3'd2,
      ADDR_TOTAL_CNT  = 3'd3,
      ADDR_F1_BYTE_LO = 3'd4,
      ADDR_F1_BYTE_HI = 3'd5,
      ADDR_F2_BYTE_LO = 3'd6,
      ADDR_F2_BYTE_HI = 3'd7
   } pd_cnt_addr_e;

   // Bit positions inside the overflow vector, also used as counter indices
   localparam int OVF_F1      = 0;
   localparam int OVF_F2      = 1;
   localparam int OVF_CAP     = 2;
   localparam int OVF_TOTAL   = 3;
   localparam int OVF_F1_BYTE = 4;
   localparam int OVF_F2_BYTE = 5;

endpackage

// File: rtl/pd_debug_sat_cnt.sv
// One statistics counter with selectable saturate/wrap behaviour.
// A clear and an increment in the same cycle leave the counter at the
// increment amount, so no event is lost across a clearing read.
module pd_debug_sat_cnt
   import pd_debug_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_CNT_WIDTH,
   parameter int INC_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc_en,
   input  logic [INC_WIDTH-1:0] inc_amt,
   input  logic                 sat_en,
   input  logic                 clr,
   output logic [WIDTH-1:0]     cnt,
   output logic                 ovf_pulse
);

   logic [WIDTH-1:0] base;
   logic [WIDTH:0]   sum;

   // Sum with one extra carry bit; the carry marks a true overflow
   always_comb begin
      base      = clr ? '0 : cnt;
      sum       = {1'b0, base} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc_amt};
      ovf_pulse = inc_en & sum[WIDTH];
   end

   // Counter register: increment (saturating or wrapping), clear, or hold
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc_en) begin
         if (sum[WIDTH] && sat_en) begin
            cnt <= '1;
         end else begin
            cnt <= sum[WIDTH-1:0];
         end
      end else if (clr) begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/pd_debug_cnt_bank.sv
// PD debug statistics counter bank: four event counters and two byte
// counters with a single-outstanding CIF read port, clear-on-read,
// global clear, hi-word shadows for atomic byte reads and sticky overflow.
module pd_debug_cnt_bank
   import pd_debug_pkg::*;
#(
   parameter int CNT_WIDTH         = DEFAULT_CNT_WIDTH,
   parameter int BYTE_CNT_WIDTH    = DEFAULT_BYTE_CNT_WIDTH,
   parameter int PACKET_SIZE_WIDTH = DEFAULT_PACKET_SIZE_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
   input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
   input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
   input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
   input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
   input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
   input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
   input  logic                         cif2cnt_c_sat_en,
   input  logic                         cif2cnt_c_clr_on_rd,
   input  logic                         cif2cnt_e_clr_all,
   input  logic                         cif2cnt_e_rd_req,
   input  logic [2:0]                   cif2cnt_c_rd_addr,
   output logic                         cnt2cif_e_rd_ack,
   output logic [31:0]                  cnt2cif_c_rd_data,
   output logic [5:0]                   cnt2cif_c_ovf
);

   localparam int HI_WIDTH = BYTE_CNT_WIDTH - RD_DATA_WIDTH;

   pd_cnt_addr_e              rd_addr;
   logic [NUM_CNT-1:0]        inc_strb;
   logic [NUM_CNT-1:0]        inc_en;
   logic [NUM_CNT-1:0]        rd_clr;
   logic [NUM_CNT-1:0]        cnt_clr;
   logic [NUM_CNT-1:0]        ovf_pulse;
   logic [CNT_WIDTH-1:0]      evt_cnt   [4];
   logic [BYTE_CNT_WIDTH-1:0] byte_cnt  [2];
   logic [HI_WIDTH-1:0]       hi_shadow [2];
   logic [RD_DATA_WIDTH-1:0]  rd_mux;

   assign rd_addr  = pd_cnt_addr_e'(cif2cnt_c_rd_addr);
   assign inc_strb = {dbg2cif_e_debug_pd_field2_byte_cnt_inc,
                      dbg2cif_e_debug_pd_field1_byte_cnt_inc,
                      dbg2cif_e_debug_pd_total_pd_cnt_inc,
                      dbg2cif_e_debug_pd_capture_match_cnt_inc,
                      dbg2cif_e_debug_pd_field2_cnt_inc,
                      dbg2cif_e_debug_pd_field1_cnt_inc};

   // Global clear discards same-cycle increments; a clearing read keeps them
   always_comb begin
      inc_en = inc_strb & {NUM_CNT{~cif2cnt_e_clr_all}};
      rd_clr = '0;
      if (cif2cnt_e_rd_req && cif2cnt_c_clr_on_rd) begin
         case (rd_addr)
            ADDR_F1_CNT:     rd_clr[OVF_F1]      = 1'b1;
            ADDR_F2_CNT:     rd_clr[OVF_F2]      = 1'b1;
            ADDR_CAP_CNT:    rd_clr[OVF_CAP]     = 1'b1;
            ADDR_TOTAL_CNT:  rd_clr[OVF_TOTAL]   = 1'b1;
            ADDR_F1_BYTE_LO: rd_clr[OVF_F1_BYTE] = 1'b1;
            ADDR_F2_BYTE_LO: rd_clr[OVF_F2_BYTE] = 1'b1;
            default:         rd_clr              = '0;
         endcase
      end
      cnt_clr = rd_clr | {NUM_CNT{cif2cnt_e_clr_all}};
   end

   for (genvar i = 0; i < 4; i++) begin : g_evt
      pd_debug_sat_cnt #(
         .WIDTH     (CNT_WIDTH),
         .INC_WIDTH (1)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc_en    (inc_en[i]),
         .inc_amt   (1'b1),
         .sat_en    (cif2cnt_c_sat_en),
         .clr       (cnt_clr[i]),
         .cnt       (evt_cnt[i]),
         .ovf_pulse (ovf_pulse[i])
      );
   end

   pd_debug_sat_cnt #(
      .WIDTH     (BYTE_CNT_WIDTH),
      .INC_WIDTH (PACKET_SIZE_WIDTH)
   ) u_f1_byte (
      .clk       (clk),
      .rst       (rst),
      .inc_en    (inc_en[OVF_F1_BYTE]),
      .inc_amt   (dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
      .sat_en    (cif2cnt_c_sat_en),
      .clr       (cnt_clr[OVF_F1_BYTE]),
      .cnt       (byte_cnt[0]),
      .ovf_pulse (ovf_pulse[OVF_F1_BYTE])
   );

   pd_debug_sat_cnt #(
      .WIDTH     (BYTE_CNT_WIDTH),
      .INC_WIDTH (PACKET_SIZE_WIDTH)
   ) u_f2_byte (
      .clk       (clk),
      .rst       (rst),
      .inc_en    (inc_en[OVF_F2_BYTE]),
      .inc_amt   (dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
      .sat_en    (cif2cnt_c_sat_en),
      .clr       (cnt_clr[OVF_F2_BYTE]),
      .cnt       (byte_cnt[1]),
      .ovf_pulse (ovf_pulse[OVF_F2_BYTE])
   );

   // Read mux over pre-update values; hi addresses return the shadow only
   always_comb begin
      rd_mux = '0;
      case (rd_addr)
         ADDR_F1_CNT:     rd_mux = RD_DATA_WIDTH'(evt_cnt[0]);
         ADDR_F2_CNT:     rd_mux = RD_DATA_WIDTH'(evt_cnt[1]);
         ADDR_CAP_CNT:    rd_mux = RD_DATA_WIDTH'(evt_cnt[2]);
         ADDR_TOTAL_CNT:  rd_mux = RD_DATA_WIDTH'(evt_cnt[3]);
         ADDR_F1_BYTE_LO: rd_mux = byte_cnt[0][RD_DATA_WIDTH-1:0];
         ADDR_F1_BYTE_HI: rd_mux = RD_DATA_WIDTH'(hi_shadow[0]);
         ADDR_F2_BYTE_LO: rd_mux = byte_cnt[1][RD_DATA_WIDTH-1:0];
         ADDR_F2_BYTE_HI: rd_mux = RD_DATA_WIDTH'(hi_shadow[1]);
         default:         rd_mux = '0;
      endcase
   end

   // Read response: one-cycle ack pulse, data held between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt2cif_e_rd_ack  <= 1'b0;
         cnt2cif_c_rd_data <= '0;
      end else begin
         cnt2cif_e_rd_ack <= cif2cnt_e_rd_req;
         if (cif2cnt_e_rd_req) begin
            cnt2cif_c_rd_data <= rd_mux;
         end
      end
   end

   // Hi shadows capture the upper byte-counter bits on every lo read
   always_ff @(posedge clk) begin
      if (rst || cif2cnt_e_clr_all) begin
         hi_shadow[0] <= '0;
         hi_shadow[1] <= '0;
      end else if (cif2cnt_e_rd_req) begin
         if (rd_addr == ADDR_F1_BYTE_LO) begin
            hi_shadow[0] <= byte_cnt[0][BYTE_CNT_WIDTH-1:RD_DATA_WIDTH];
         end
         if (rd_addr == ADDR_F2_BYTE_LO) begin
            hi_shadow[1] <= byte_cnt[1][BYTE_CNT_WIDTH-1:RD_DATA_WIDTH];
         end
      end
   end

   // Sticky overflow flags, cleared only by reset or global clear
   always_ff @(posedge clk) begin
      if (rst || cif2cnt_e_clr_all) begin
         cnt2cif_c_ovf <= '0;
      end else begin
         cnt2cif_c_ovf <= cnt2cif_c_ovf | ovf_pulse;
      end
   end

endmodule

// File: tb/tb_pd_debug_cnt_bank.sv
// Self-checking bench for pd_debug_cnt_bank. Narrow counter widths let
// saturation and wrap be reached in a few thousand cycles.
module tb_pd_debug_cnt_bank;

   localparam int CW = 8;
   localparam int BW = 40;
   localparam int PW = 30;

   logic          clk;
   logic          rst;
   logic [5:0]    strb;
   logic [PW-1:0] amount;
   logic          sat_en;
   logic          clr_on_rd;
   logic          clr_all;
   logic          rd_req;
   logic [2:0]    rd_addr;
   logic          rd_ack;
   logic [31:0]   rd_data;
   logic [5:0]    ovf;

   int tests;
   int fails;

   longint unsigned m_cnt [6];
   longint unsigned m_hi  [2];
   logic [5:0]      m_ovf;
   logic            m_ack;
   logic [31:0]     m_data;

   pd_debug_cnt_bank #(
      .CNT_WIDTH         (CW),
      .BYTE_CNT_WIDTH    (BW),
      .PACKET_SIZE_WIDTH (PW)
   ) dut (
      .clk                                           (clk),
      .rst                                           (rst),
      .dbg2cif_e_debug_pd_field1_cnt_inc             (strb[0]),
      .dbg2cif_e_debug_pd_field2_cnt_inc             (strb[1]),
      .dbg2cif_e_debug_pd_capture_match_cnt_inc      (strb[2]),
      .dbg2cif_e_debug_pd_total_pd_cnt_inc           (strb[3]),
      .dbg2cif_e_debug_pd_field1_byte_cnt_inc        (strb[4]),
      .dbg2cif_e_debug_pd_field2_byte_cnt_inc        (strb[5]),
      .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount (amount),
      .cif2cnt_c_sat_en                              (sat_en),
      .cif2cnt_c_clr_on_rd                           (clr_on_rd),
      .cif2cnt_e_clr_all                             (clr_all),
      .cif2cnt_e_rd_req                              (rd_req),
      .cif2cnt_c_rd_addr                             (rd_addr),
      .cnt2cif_e_rd_ack                              (rd_ack),
      .cnt2cif_c_rd_data                             (rd_data),
      .cnt2cif_c_ovf                                 (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint unsigned cntMax(input int i);
      return (i < 4) ? ((64'd1 << CW) - 64'd1) : ((64'd1 << BW) - 64'd1);
   endfunction

   function automatic bit readClears(input int i);
      int a;
      a = int'(rd_addr);
      if (!(rd_req && clr_on_rd)) return 1'b0;
      if (i < 4) return a == i;
      if (i == 4) return a == 4;
      return a == 6;
   endfunction

   // Reference model: one call per clock edge, from the counters' arithmetic rules
   function automatic void modelEdge();
      longint unsigned new_hi [2];
      logic [31:0]     rd_val;
      if (rst) begin
         for (int i = 0; i < 6; i++) m_cnt[i] = 0;
         m_hi[0] = 0;
         m_hi[1] = 0;
         m_ovf   = '0;
         m_ack   = 1'b0;
         m_data  = '0;
         return;
      end
      new_hi[0] = m_hi[0];
      new_hi[1] = m_hi[1];
      case (int'(rd_addr))
         0, 1, 2, 3: rd_val = 32'(m_cnt[int'(rd_addr)] % (64'd1 << 32));
         4:          rd_val = 32'(m_cnt[4] % (64'd1 << 32));
         5:          rd_val = 32'(m_hi[0]);
         6:          rd_val = 32'(m_cnt[5] % (64'd1 << 32));
         default:    rd_val = 32'(m_hi[1]);
      endcase
      if (rd_req && int'(rd_addr) == 4) new_hi[0] = m_cnt[4] >> 32;
      if (rd_req && int'(rd_addr) == 6) new_hi[1] = m_cnt[5] >> 32;
      m_ack = rd_req;
      if (rd_req) m_data = rd_val;
      if (clr_all) begin
         for (int i = 0; i < 6; i++) m_cnt[i] = 0;
         m_hi[0] = 0;
         m_hi[1] = 0;
         m_ovf   = '0;
      end else begin
         for (int i = 0; i < 6; i++) begin
            longint unsigned base;
            longint unsigned inc;
            longint unsigned sum;
            longint unsigned top;
            top  = cntMax(i);
            base = readClears(i) ? 0 : m_cnt[i];
            if (strb[i]) begin
               inc = (i < 4) ? 64'd1 : 64'(amount);
               sum = base + inc;
               if (sum > top) begin
                  m_ovf[i] = 1'b1;
                  m_cnt[i] = sat_en ? top : sum - (top + 1);
               end else begin
                  m_cnt[i] = sum;
               end
            end else begin
               m_cnt[i] = base;
            end
         end
         m_hi[0] = new_hi[0];
         m_hi[1] = new_hi[1];
      end
   endfunction

   // One clock: model the edge, compare outputs after it, drop single-cycle pulses
   task automatic applyStimulus();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("rd_ack", 64'(rd_ack), 64'(m_ack));
      checkOutput("rd_data", 64'(rd_data), 64'(m_data));
      checkOutput("ovf", 64'(ovf), 64'(m_ovf));
      @(negedge clk);
      strb    = '0;
      rd_req  = 1'b0;
      clr_all = 1'b0;
      rst     = 1'b0;
   endtask

   task automatic doRead(input int addr);
      rd_req  = 1'b1;
      rd_addr = 3'(addr);
      applyStimulus();
   endtask

   task automatic repeatStrobe(input logic [5:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         strb = s;
         applyStimulus();
      end
   endtask

   task automatic globalClear();
      clr_all = 1'b1;
      applyStimulus();
   endtask

   initial begin
      longint unsigned big;
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      strb      = '0;
      amount    = '0;
      sat_en    = 1'b0;
      clr_on_rd = 1'b0;
      clr_all   = 1'b0;
      rd_req    = 1'b0;
      rd_addr   = '0;
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_hi[0] = 0;
      m_hi[1] = 0;
      m_ovf   = '0;
      m_ack   = 1'b0;
      m_data  = '0;

      // Reset, then every address reads zero with a one-cycle ack
      rst = 1'b1;
      applyStimulus();
      rst = 1'b1;
      applyStimulus();
      checkOutput("t1_ovf_reset", 64'(ovf), 64'd0);
      for (int a = 0; a < 8; a++) begin
         doRead(a);
         checkOutput("t1_ack", 64'(rd_ack), 64'd1);
         checkOutput("t1_zero", 64'(rd_data), 64'd0);
      end
      applyStimulus();
      checkOutput("t1_ack_pulse", 64'(rd_ack), 64'd0);

      // All event strobes for five cycles, then non-destructive reads
      repeatStrobe(6'b001111, 5);
      for (int a = 0; a < 4; a++) begin
         doRead(a);
         checkOutput("t2_evt5", 64'(rd_data), 64'd5);
      end
      doRead(0);
      checkOutput("t2_reread", 64'(rd_data), 64'd5);

      // Field1 byte counter: atomic lo/hi pair, then wrap past full scale
      amount = '1;
      repeatStrobe(6'b010000, 300);
      big  = 64'd300 * 64'(amount);
      strb = 6'b010000;
      doRead(4);
      checkOutput("t3_lo", 64'(rd_data), big % (64'd1 << 32));
      repeatStrobe(6'b010000, 5);
      doRead(5);
      checkOutput("t3_hi_shadow", 64'(rd_data), big >> 32);
      repeatStrobe(6'b010000, 800);
      checkOutput("t3_byte_wrap_ovf", 64'(ovf[4]), 64'd1);
      doRead(4);
      doRead(5);

      // Field2 byte counter saturates at all-ones
      globalClear();
      sat_en = 1'b1;
      repeatStrobe(6'b100000, 1030);
      doRead(6);
      checkOutput("t3_sat_lo", 64'(rd_data), 64'hFFFF_FFFF);
      doRead(7);
      checkOutput("t3_sat_hi", 64'(rd_data), (64'd1 << (BW - 32)) - 64'd1);
      checkOutput("t3_sat_ovf", 64'(ovf), 64'b100000);

      // Event counter crossing all-ones: saturate, then wrap
      globalClear();
      sat_en = 1'b1;
      repeatStrobe(6'b000001, (1 << CW) - 2);
      repeatStrobe(6'b000001, 3);
      doRead(0);
      checkOutput("t4_sat", 64'(rd_data), (64'd1 << CW) - 64'd1);
      checkOutput("t4_sat_ovf", 64'(ovf[0]), 64'd1);
      globalClear();
      sat_en = 1'b0;
      repeatStrobe(6'b000001, (1 << CW) - 2);
      repeatStrobe(6'b000001, 3);
      doRead(0);
      checkOutput("t4_wrap", 64'(rd_data), 64'd1);
      checkOutput("t4_wrap_ovf", 64'(ovf[0]), 64'd1);

      // Clearing read coincident with an increment keeps the increment
      globalClear();
      repeatStrobe(6'b001000, 7);
      clr_on_rd = 1'b1;
      strb      = 6'b001000;
      doRead(3);
      checkOutput("t5_cor_data", 64'(rd_data), 64'd7);
      doRead(3);
      checkOutput("t5_cor_next", 64'(rd_data), 64'd1);
      clr_on_rd = 1'b0;

      // Global clear with a read and a strobe, then reset during a read
      globalClear();
      repeatStrobe(6'b000001, 9);
      clr_all = 1'b1;
      strb    = 6'b000001;
      doRead(0);
      checkOutput("t6_pre_clear", 64'(rd_data), 64'd9);
      doRead(0);
      checkOutput("t6_cleared", 64'(rd_data), 64'd0);
      checkOutput("t6_ovf", 64'(ovf), 64'd0);
      repeatStrobe(6'b000001, 2);
      rst = 1'b1;
      doRead(0);
      checkOutput("t6_rst_no_ack", 64'(rd_ack), 64'd0);
      applyStimulus();
      checkOutput("t6_rst_no_late_ack", 64'(rd_ack), 64'd0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 4000; n++) begin
         int sel;
         strb = 6'($urandom());
         sel  = int'($urandom_range(0, 3));
         if (sel == 0)      amount = '0;
         else if (sel == 1) amount = '1;
         else               amount = PW'($urandom());
         rd_req    = ($urandom_range(0, 2) == 0);
         rd_addr   = 3'($urandom());
         clr_all   = ($urandom_range(0, 999) == 0);
         rst       = ($urandom_range(0, 1999) == 0);
         clr_on_rd = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 199) == 0) sat_en = ~sat_en;
         applyStimulus();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
